// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor, line idle level.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam logic        UART_IDLE_LVL        = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } tx_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned    CNT_W   = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_end = (cnt == CNT_MAX);

    // Synchronous clear has priority; otherwise wrap at the bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// FIFO reader and 8N1 serializer: pops one byte per frame, flags frame and packet ends.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned WIDTH        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_dout_last,
    output logic             tx,
    output logic             busy,
    output logic             frame_done,
    output logic             pkt_done
);

    localparam int unsigned      BIT_W    = cnt_width(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    tx_state_e        state;
    tx_state_e        state_nxt;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_nxt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_cnt_nxt;
    logic             last_q;
    logic             last_nxt;
    logic             tx_nxt;
    logic             busy_nxt;
    logic             frame_done_nxt;
    logic             pkt_done_nxt;
    logic             baud_clear;
    logic             bit_end;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (baud_clear),
        .bit_end(bit_end)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, pop request and next values of the datapath/output registers.
    always_comb begin
        state_nxt      = state;
        shift_nxt      = shift;
        bit_cnt_nxt    = bit_cnt;
        last_nxt       = last_q;
        tx_nxt         = tx;
        frame_done_nxt = 1'b0;
        pkt_done_nxt   = 1'b0;
        fifo_rd_en     = 1'b0;

        case (state)
            IDLE: begin
                fifo_rd_en = !fifo_empty;
                if (!fifo_empty) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                // FIFO data and its last flag are only valid this cycle.
                shift_nxt = fifo_dout;
                last_nxt  = fifo_dout_last;
                tx_nxt    = 1'b0;
                state_nxt = START;
            end
            START: begin
                if (bit_end) begin
                    tx_nxt      = shift[0];
                    bit_cnt_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt   = shift >> 1;
                    bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_LAST) begin
                        tx_nxt    = UART_IDLE_LVL;
                        state_nxt = STOP;
                    end else begin
                        tx_nxt = shift_nxt[0];
                    end
                end
            end
            STOP: begin
                tx_nxt = UART_IDLE_LVL;
                if (bit_end) begin
                    frame_done_nxt = 1'b1;
                    pkt_done_nxt   = last_q;
                    last_nxt       = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                tx_nxt    = UART_IDLE_LVL;
                state_nxt = IDLE;
            end
        endcase

        busy_nxt   = (state_nxt != IDLE);
        // Restart the bit period on every state entry and hold it while not on the line.
        baud_clear = (state_nxt != state) || (state == IDLE) || (state == LOAD);
    end

    // Datapath and registered outputs; tx returns to idle level asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift      <= '0;
            bit_cnt    <= '0;
            last_q     <= 1'b0;
            tx         <= UART_IDLE_LVL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pkt_done   <= 1'b0;
        end else begin
            shift      <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            last_q     <= last_nxt;
            tx         <= tx_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
            pkt_done   <= pkt_done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain driving a registered-output sync FIFO model.
module tb_uart_tx_drain;

    localparam int unsigned CPB   = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic         fifo_full;
    logic         fifo_rd_en;
    logic [W-1:0] fifo_dout;
    logic         fifo_dout_last;
    logic         tx;
    logic         busy;
    logic         frame_done;
    logic         pkt_done;

    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         wr_last;
    logic [W-1:0] mem [DEPTH];
    logic         mem_last [DEPTH];
    logic [2:0]   wp;
    logic [2:0]   rp;
    logic [3:0]   count;

    int checks = 0;
    int errors = 0;

    int fd_count   = 0;
    int pd_count   = 0;
    int pd_alone   = 0;
    int last_pd_at = 0;
    int rd_viol    = 0;

    logic         rx_active;
    int           rx_cnt;
    int           idle_run;
    int           frame_err = 0;
    logic [7:0]   rx_shift;
    logic [7:0]   rx_q [$];
    int           gap_q [$];

    uart_tx_drain #(
        .CLKS_PER_BIT(CPB),
        .WIDTH       (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_dout     (fifo_dout),
        .fifo_dout_last(fifo_dout_last),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done),
        .pkt_done      (pkt_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (count == 4'd0);
    assign fifo_full  = (count == 4'(DEPTH));

    // Sync FIFO: registered read data, last flag valid only the cycle after a pop.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp             <= 3'd0;
            rp             <= 3'd0;
            count          <= 4'd0;
            fifo_dout      <= '0;
            fifo_dout_last <= 1'b0;
        end else begin
            fifo_dout_last <= 1'b0;
            if (wr_en && !fifo_full) begin
                mem[wp]      <= wr_data;
                mem_last[wp] <= wr_last;
                wp           <= wp + 3'd1;
            end
            if (fifo_rd_en && !fifo_empty) begin
                fifo_dout      <= mem[rp];
                fifo_dout_last <= mem_last[rp];
                rp             <= rp + 3'd1;
            end
            count <= count + 4'(wr_en && !fifo_full) - 4'(fifo_rd_en && !fifo_empty);
        end
    end

    // Pulse and protocol event counters.
    always @(negedge clk) begin
        if (frame_done) begin
            fd_count <= fd_count + 1;
            if (pkt_done) last_pd_at <= fd_count + 1;
        end
        if (pkt_done) pd_count <= pd_count + 1;
        if (pkt_done && !frame_done) pd_alone <= pd_alone + 1;
        if (fifo_rd_en && fifo_empty) rd_viol <= rd_viol + 1;
    end

    // Line decoder: mid-bit sampling of each frame, records bytes and idle gaps.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            rx_active <= 1'b0;
            rx_cnt    <= 0;
            idle_run  <= 0;
            rx_shift  <= 8'h00;
        end else if (!rx_active) begin
            if (tx == 1'b0) begin
                rx_active <= 1'b1;
                rx_cnt    <= 1;
                gap_q.push_back(idle_run);
            end else begin
                idle_run <= idle_run + 1;
            end
        end else begin
            if (rx_cnt == CPB / 2 && tx !== 1'b0) frame_err <= frame_err + 1;
            if (rx_cnt >= CPB + CPB / 2 && rx_cnt <= CPB * W + CPB / 2 && (rx_cnt % CPB) == CPB / 2)
                rx_shift <= {tx, rx_shift[7:1]};
            if (rx_cnt == CPB * (W + 1) + CPB / 2) begin
                if (tx !== 1'b1) frame_err <= frame_err + 1;
                rx_q.push_back(rx_shift);
            end
            if (rx_cnt == CPB * (W + 2) - 1) begin
                rx_active <= 1'b0;
                idle_run  <= 0;
            end
            rx_cnt <= rx_cnt + 1;
        end
    end

    // Push one byte for one clock; acc tells whether the FIFO had room.
    task automatic push(input logic [7:0] d, input logic l, output bit acc);
        acc     = !fifo_full;
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = l;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int i;
        i = 0;
        while (rx_q.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        wr_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, busy, fifo_rd_en, frame_done, pkt_done} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 10000", {tx, busy, fifo_rd_en, frame_done, pkt_done});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx, busy, fifo_rd_en, frame_done, pkt_done} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_release: got %b expected 10000", {tx, busy, fifo_rd_en, frame_done, pkt_done});
        end
    endtask

    task automatic test_empty_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, fifo_rd_en} !== 3'b100) begin
                errors++;
                $display("FAIL empty_idle cycle %0d: tx/busy/rd_en got %b expected 100", i, {tx, busy, fifo_rd_en});
            end
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] frame;
        int fd0, pd0, base;
        bit acc;
        frame = {1'b1, 8'hA5, 1'b0};
        fd0   = fd_count;
        pd0   = pd_count;
        base  = rx_q.size();
        push(8'hA5, 1'b0, acc);
        checks++;
        if (fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL single_pop: rd_en got %b expected 1", fifo_rd_en);
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL single_load_tx: got %b expected 1", tx);
        end
        for (int k = 0; k < int'(CPB * 10); k++) begin
            @(negedge clk);
            checks++;
            if (tx !== frame[k / CPB]) begin
                errors++;
                $display("FAIL single_tx cycle %0d: got %b expected %b", k, tx, frame[k / CPB]);
            end
        end
        @(negedge clk);
        checks++;
        if ({frame_done, pkt_done, tx} !== 3'b101) begin
            errors++;
            $display("FAIL single_frame_done: fd/pd/tx got %b expected 101", {frame_done, pkt_done, tx});
        end
        repeat (4) @(negedge clk);
        checks++;
        if (fd_count - fd0 != 1 || pd_count - pd0 != 0) begin
            errors++;
            $display("FAIL single_pulses: frame_done %0d pkt_done %0d expected 1 0", fd_count - fd0, pd_count - pd0);
        end
        checks++;
        if (rx_q.size() - base != 1 || rx_q[base] !== 8'hA5) begin
            errors++;
            $display("FAIL single_rx: got %0d bytes first %h expected 1 byte a5", rx_q.size() - base, rx_q[base]);
        end
    endtask

    task automatic test_packet();
        logic [7:0] exp_b [3];
        int fd0, pd0, pa0, fe0, base, gbase;
        bit acc, ok;
        exp_b = '{8'h01, 8'h02, 8'h03};
        fd0   = fd_count;
        pd0   = pd_count;
        pa0   = pd_alone;
        fe0   = frame_err;
        base  = rx_q.size();
        gbase = gap_q.size();
        push(8'h01, 1'b0, acc);
        push(8'h02, 1'b0, acc);
        push(8'h03, 1'b1, acc);
        wait_rx(base + 3, 400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL packet_timeout: got %0d bytes expected 3", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[base + i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL packet_byte %0d: got %h expected %h", i, rx_q[base + i], exp_b[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (gap_q[gbase + i] != 2) begin
                    errors++;
                    $display("FAIL packet_gap %0d: got %0d idle cycles expected 2", i, gap_q[gbase + i]);
                end
            end
        end
        repeat (8) @(negedge clk);
        checks++;
        if (fd_count - fd0 != 3 || pd_count - pd0 != 1) begin
            errors++;
            $display("FAIL packet_pulses: frame_done %0d pkt_done %0d expected 3 1", fd_count - fd0, pd_count - pd0);
        end
        checks++;
        if (last_pd_at != fd0 + 3 || pd_alone != pa0) begin
            errors++;
            $display("FAIL packet_pkt_done_align: at frame %0d alone %0d expected 3 0", last_pd_at - fd0, pd_alone - pa0);
        end
        checks++;
        if (frame_err != fe0) begin
            errors++;
            $display("FAIL packet_framing: got %0d errors expected 0", frame_err - fe0);
        end
    endtask

    task automatic test_full_fifo();
        logic [7:0] exp_q [$];
        logic [7:0] d;
        int base, rv0, seen, nacc;
        bit acc, prev_busy, done;
        base = rx_q.size();
        rv0  = rd_viol;
        nacc = 0;
        for (int i = 0; i < 11; i++) begin
            d = (i < 8) ? 8'(17 * (i + 1)) : 8'(8'hE1 + i - 8);
            push(d, 1'b0, acc);
            if (acc) begin
                exp_q.push_back(d);
                nacc++;
            end
            // keep wr_en high across consecutive attempts
        end
        checks++;
        if (nacc != 9) begin
            errors++;
            $display("FAIL full_accepted: got %0d pushes accepted expected 9", nacc);
        end
        seen      = 0;
        done      = 1'b0;
        prev_busy = busy;
        for (int i = 0; i < 800 && !done; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen++;
                if (seen == nacc) done = 1'b1;
            end
            if (!done) prev_busy = busy;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL full_timeout: got %0d frames expected %0d", seen, nacc);
        end else begin
            checks++;
            if (prev_busy !== 1'b1) begin
                errors++;
                $display("FAIL full_busy_before: got %b expected 1", prev_busy);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL full_busy_after: got %b expected 0", busy);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rx_q.size() - base != exp_q.size()) begin
            errors++;
            $display("FAIL full_count: got %0d bytes expected %0d", rx_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[base + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL full_byte %0d: got %h expected %h", i, rx_q[base + i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rd_viol != rv0) begin
            errors++;
            $display("FAIL full_rd_en_empty: got %0d pops while empty expected 0", rd_viol - rv0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fd0, fe0, base;
        bit acc, ok;
        push(8'h3C, 1'b0, acc);
        repeat (19) @(negedge clk);
        checks++;
        if ({tx, busy} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_pre: tx/busy got %b expected 11", {tx, busy});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({tx, busy, fifo_rd_en, frame_done, pkt_done} !== 5'b10000) begin
            errors++;
            $display("FAIL midrst_async: got %b expected 10000", {tx, busy, fifo_rd_en, frame_done, pkt_done});
        end
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        fd0  = fd_count;
        fe0  = frame_err;
        base = rx_q.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy} !== 2'b10) begin
                errors++;
                $display("FAIL midrst_idle cycle %0d: tx/busy got %b expected 10", i, {tx, busy});
            end
        end
        push(8'h55, 1'b0, acc);
        wait_rx(base + 1, 200, ok);
        repeat (8) @(negedge clk);
        checks++;
        if (!ok || rx_q.size() - base != 1 || rx_q[base] !== 8'h55) begin
            errors++;
            $display("FAIL midrst_rx: got %0d bytes first %h expected 1 byte 55", rx_q.size() - base, rx_q[base]);
        end
        checks++;
        if (fd_count - fd0 != 1 || frame_err != fe0) begin
            errors++;
            $display("FAIL midrst_frame: frame_done %0d framing %0d expected 1 0", fd_count - fd0, frame_err - fe0);
        end
    endtask

    task automatic test_push_pop();
        int base;
        bit acc0, acc1, ok;
        base = rx_q.size();
        push(8'h0F, 1'b0, acc0);
        checks++;
        if (fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_pop: rd_en got %b expected 1", fifo_rd_en);
        end
        push(8'h10, 1'b0, acc1);
        checks++;
        if ({acc0, acc1} !== 2'b11) begin
            errors++;
            $display("FAIL pushpop_accept: got %b expected 11", {acc0, acc1});
        end
        wait_rx(base + 2, 300, ok);
        repeat (60) @(negedge clk);
        checks++;
        if (!ok || rx_q.size() - base != 2) begin
            errors++;
            $display("FAIL pushpop_count: got %0d bytes expected 2", rx_q.size() - base);
        end else begin
            checks++;
            if ({rx_q[base], rx_q[base + 1]} !== 16'h0F10) begin
                errors++;
                $display("FAIL pushpop_order: got %h %h expected 0f 10", rx_q[base], rx_q[base + 1]);
            end
        end
        checks++;
        if ({fifo_empty, busy, tx} !== 3'b101) begin
            errors++;
            $display("FAIL pushpop_final: empty/busy/tx got %b expected 101", {fifo_empty, busy, tx});
        end
    endtask

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        test_reset();
        test_empty_idle();
        test_single_byte();
        test_packet();
        test_full_fifo();
        test_reset_mid_frame();
        test_push_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
